// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, keeps an in-order prefetch queue, and handles redirect flush and HALT.
// Defining IFU_PERF_CNT_EN adds the instr_count output, a free-running count of consumed instructions.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                QDEPTH   = 2,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       instr_count
`endif
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam int SUM_W = CNT_W + 2;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_halted;
  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_occ;
  logic [CNT_W-1:0]  r_inflight;
  logic [CNT_W-1:0]  r_drop;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W-1:0]  r_tag_rd;
  logic [PTR_W-1:0]  r_tag_wr;
  logic [31:0]       r_q_data [QDEPTH];
  logic [ADDR_W-1:0] r_q_pc   [QDEPTH];
  logic [ADDR_W-1:0] r_tag_mem[QDEPTH];

  logic [SUM_W-1:0]  w_sum;
  logic              w_req_valid;
  logic              w_req_fire;
  logic              w_rsp_push;
  logic              w_rsp_drop;
  logic              w_empty;
  logic              w_instr_fire;
  logic              w_head_halt;

  // Both handshakes are strict valid/ready: a transfer happens only in a cycle where valid and
  // ready are high together; valid never waits on ready, and data is stable while valid is held.
  // Every slot (queued, in flight, or owed as a drop) is reserved before a request is issued,
  // so a response always finds room and the queue cannot overflow.
  assign w_sum        = SUM_W'(r_occ) + SUM_W'(r_inflight) + SUM_W'(r_drop);
  assign w_req_valid  = !rst && (r_state == ST_RUN) && (w_sum < SUM_W'(QDEPTH)) && !redirect_valid;
  assign w_req_fire   = w_req_valid && imem_req_ready;
  assign w_rsp_drop   = imem_rsp_valid && (r_drop != '0);
  assign w_rsp_push   = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
  assign w_empty      = (r_occ == '0);
  assign w_instr_fire = !w_empty && instr_ready;
  assign w_head_halt  = (r_q_data[r_head][31:26] == OP_HALT);

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign instr_valid    = !w_empty;
  assign instruction    = w_empty ? '0 : r_q_data[r_head];
  assign instr_pc       = w_empty ? '0 : r_q_pc[r_head];
  assign halted         = r_halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_state    <= ST_RUN;
      r_halted   <= 1'b0;
      r_occ      <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_tag_rd   <= '0;
      r_tag_wr   <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight becomes a drop; a response landing now is already discarded.
      r_pc       <= redirect_pc;
      r_state    <= ST_RUN;
      r_halted   <= 1'b0;
      r_occ      <= '0;
      r_inflight <= '0;
      r_drop     <= r_drop + r_inflight - CNT_W'(imem_rsp_valid);
      r_head     <= '0;
      r_tail     <= '0;
      r_tag_rd   <= '0;
      r_tag_wr   <= '0;
    end else begin
      if (w_req_fire) begin
        r_pc     <= r_pc + ADDR_W'(PC_STEP);
        r_tag_wr <= r_tag_wr + PTR_W'(1);
      end
      if (w_rsp_drop) begin
        r_drop <= r_drop - CNT_W'(1);
      end
      if (w_rsp_push) begin
        r_tail   <= r_tail + PTR_W'(1);
        r_tag_rd <= r_tag_rd + PTR_W'(1);
      end
      r_inflight <= r_inflight + CNT_W'(w_req_fire) - CNT_W'(w_rsp_push);
      r_occ      <= r_occ + CNT_W'(w_rsp_push) - CNT_W'(w_instr_fire);
      if (w_instr_fire) begin
        r_head <= r_head + PTR_W'(1);
        if (w_head_halt) begin
          r_state  <= ST_HALTED;
          r_halted <= 1'b1;
        end
      end
    end
  end

  // The tag FIFO runs in lockstep with accepted requests, so its head is the PC of the next response.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_tag_mem[r_tag_wr] <= r_pc;
    end
    if (w_rsp_push) begin
      r_q_data[r_tail] <= imem_rsp_data;
      r_q_pc[r_tail]   <= r_tag_mem[r_tag_rd];
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_instr_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_count <= '0;
    end else if (w_instr_fire) begin
      r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: an in-order memory model with random latency plus a queue-based stream model.
// Build with IFU_PERF_CNT_EN defined to also cover the instr_count port.
module tb_instr_fetch_unit;

  localparam int          QDEPTH  = 2;
  localparam logic [31:0] NO_HALT = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] instr_count;
`endif

  instr_fetch_unit #(
    .ADDR_W  (32),
    .RESET_PC(32'h0),
    .QDEPTH  (QDEPTH),
    .PC_STEP (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .instr_pc      (instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halted        (halted)
`ifdef IFU_PERF_CNT_EN
    ,
    .instr_count   (instr_count)
`endif
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          rdy;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] exp_q[$];
  int          checks, errors, cyc, cur_epoch, occ_m, accepted, delivered, exp_count;
  int          lat_min, lat_max;
  logic [31:0] exp_req_pc, halt_addr, halt_next, first_pc, first_word, first_req;
  logic        halted_exp, got_first, got_first_req;
  logic [25:0] salt;

  // Memory contents: a word derived from its address, with one optional HALT location.
  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == halt_addr) return 32'hFC00_0000;
    return ((a >> 2) + 32'd1) ^ {6'b0, salt};
  endfunction

  function automatic int stale_pending();
    int n = 0;
    foreach (pend_q[i]) if (pend_q[i].epoch != cur_epoch) n++;
    return n;
  endfunction

  task automatic model_reset();
    pend_q.delete();
    exp_q.delete();
    occ_m         = 0;
    cur_epoch     = cur_epoch + 1;
    exp_req_pc    = 32'h0;
    halted_exp    = 1'b0;
    exp_count     = 0;
    accepted      = 0;
    delivered     = 0;
    got_first     = 1'b0;
    got_first_req = 1'b0;
    halt_addr     = NO_HALT;
    halt_next     = NO_HALT;
    salt          = '0;
  endtask

  // One clock: check outputs against the model, advance on the edge, then drive memory responses.
  task automatic cycle();
    logic        req_fire, ins_fire, rsp_fire, redir, exp_rv;
    logic [31:0] w, p, req_addr;
    pend_t       e;
    #1;
    redir    = redirect_valid;
    rsp_fire = imem_rsp_valid;
    req_fire = imem_req_valid && imem_req_ready;
    ins_fire = instr_valid && instr_ready;
    req_addr = imem_req_addr;
    exp_rv   = !halted_exp && ((exp_q.size() + stale_pending()) < QDEPTH) && !redir;
    checks++;
    if (imem_req_valid !== exp_rv) begin
      errors++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
    end
    if (exp_rv) begin
      checks++;
      if (imem_req_addr !== exp_req_pc) begin
        errors++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_req_pc);
      end
    end
    checks++;
    if (instr_valid !== (occ_m > 0)) begin
      errors++;
      $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, (occ_m > 0));
    end
    checks++;
    if (halted !== halted_exp) begin
      errors++;
      $display("FAIL halted cyc=%0d got=%b exp=%b", cyc, halted, halted_exp);
    end
    if (ins_fire && occ_m > 0) begin
      w = word(exp_q[0]);
      checks++;
      if (instr_pc !== exp_q[0] || instruction !== w) begin
        errors++;
        $display("FAIL instr_word cyc=%0d got pc=%h data=%h exp pc=%h data=%h",
                 cyc, instr_pc, instruction, exp_q[0], w);
      end
    end
    @(posedge clk);
    cyc++;
    if (rsp_fire && pend_q.size() > 0) begin
      e = pend_q.pop_front();
      if (e.epoch == cur_epoch && !redir) occ_m++;
    end
    if (req_fire) begin
      pend_q.push_back('{addr: req_addr, epoch: cur_epoch,
                         rdy: cyc + $urandom_range(lat_max, lat_min) - 1});
      exp_q.push_back(exp_req_pc);
      exp_req_pc = exp_req_pc + 32'd4;
      accepted++;
      if (!got_first_req) begin
        got_first_req = 1'b1;
        first_req     = req_addr;
      end
    end
    if (ins_fire) exp_count++;
    if (ins_fire && occ_m > 0) begin
      p = exp_q.pop_front();
      w = word(p);
      occ_m--;
      delivered++;
      if (w[31:26] == 6'b111111) halted_exp = 1'b1;
      if (!got_first) begin
        got_first  = 1'b1;
        first_pc   = p;
        first_word = w;
      end
    end
    if (redir) begin
      exp_q.delete();
      occ_m         = 0;
      cur_epoch     = cur_epoch + 1;
      exp_req_pc    = redirect_pc;
      halted_exp    = 1'b0;
      halt_addr     = halt_next;
      got_first     = 1'b0;
      got_first_req = 1'b0;
    end
    #1;
    redirect_valid = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].rdy <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(pend_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
  endtask

  task automatic apply_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    checks++;
    if ({imem_req_valid, instr_valid, halted} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got req/instr/halted=%b exp=000", {imem_req_valid, instr_valid, halted});
    end
    checks++;
    if (instruction !== 32'h0 || instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got instr=%h pc=%h exp 0/0", instruction, instr_pc);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_pc    = '0;
    lat_min        = 1;
    lat_max        = 1;
    apply_reset();
  endtask

  task automatic test_stream();
    apply_reset();
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    checks++;
    if (first_pc !== 32'h0 || first_word !== 32'h1) begin
      errors++;
      $display("FAIL stream_first got pc=%h data=%h exp 0/00000001", first_pc, first_word);
    end
    checks++;
    if (delivered < 10) begin
      errors++;
      $display("FAIL stream_rate got %0d words exp >=10", delivered);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (accepted !== QDEPTH || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall got accepted=%0d req_valid=%b exp %0d/0", accepted, imem_req_valid, QDEPTH);
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (first_pc !== 32'h0 || delivered < 3 || accepted < 3) begin
      errors++;
      $display("FAIL bp_resume got first=%h delivered=%0d accepted=%0d", first_pc, delivered, accepted);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    lat_min = 3; lat_max = 3;
    imem_req_ready = 1'b1; instr_ready = 1'b0;
    cycle();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    halt_next      = NO_HALT;
    cycle();
    lat_min = 1; lat_max = 1;
    instr_ready = 1'b1;
    for (int i = 0; i < 15; i++) cycle();
    checks++;
    if (first_req !== 32'h100 || first_pc !== 32'h100 || first_word !== word(32'h100)) begin
      errors++;
      $display("FAIL redirect_first got req=%h pc=%h data=%h exp 100/100/%h",
               first_req, first_pc, first_word, word(32'h100));
    end
    checks++;
    if (delivered < 3) begin
      errors++;
      $display("FAIL redirect_resume got %0d words exp >=3", delivered);
    end
  endtask

  task automatic test_halt();
    apply_reset();
    halt_addr = 32'h8;
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_set got %b exp 1", halted);
    end
    accepted = 0;
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (accepted !== 0 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_stop got accepted=%0d req_valid=%b exp 0/0", accepted, imem_req_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    halt_next      = NO_HALT;
    cycle();
    for (int i = 0; i < 6; i++) cycle();
    checks++;
    if (halted !== 1'b0 || first_req !== 32'h40 || first_pc !== 32'h40) begin
      errors++;
      $display("FAIL halt_resume got halted=%b req=%h pc=%h exp 0/40/40", halted, first_req, first_pc);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; instr_ready = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_fill got instr_valid=%b exp 1", instr_valid);
    end
    apply_reset();
    instr_ready = 1'b1;
    cycle();
    checks++;
    if (first_req !== 32'h0) begin
      errors++;
      $display("FAIL midrst_addr got %h exp 00000000", first_req);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, rpc;
    apply_reset();
    salt    = 26'($urandom());
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        r   = $urandom();
        rpc = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF0 : {r[31:2], 2'b00};
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
        halt_next      = ($urandom_range(0, 2) == 0) ? rpc + 32'd4 * $urandom_range(1, 6) : NO_HALT;
      end
      cycle();
    end
    checks++;
    if (delivered < 200) begin
      errors++;
      $display("FAIL random_progress got %0d words exp >=200", delivered);
    end
  endtask

`ifdef IFU_PERF_CNT_EN
  task automatic test_perf_count();
    logic done_redir;
    apply_reset();
    done_redir = 1'b0;
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 200 && exp_count < 10; i++) begin
      instr_ready = 1'b1;
      if (!done_redir && exp_count >= 5) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        halt_next      = NO_HALT;
        done_redir     = 1'b1;
      end
      cycle();
    end
    instr_ready = 1'b0;
    cycle();
    cycle();
    checks++;
    if (exp_count !== 10 || !done_redir) begin
      errors++;
      $display("FAIL perf_budget got %0d handshakes exp 10", exp_count);
    end
    checks++;
    if (instr_count !== 32'd10) begin
      errors++;
      $display("FAIL perf_count got %0d exp 10", instr_count);
    end
  endtask
`endif

  initial begin
    checks = 0; errors = 0; cyc = 0; cur_epoch = 0;
    rst = 1'b1; imem_req_ready = 1'b0; instr_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_reset_mid();
    test_random();
`ifdef IFU_PERF_CNT_EN
    test_perf_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
